// File: rtl/counter_meter.sv
// Passive monitor for a counter's ld/dn handshake: counts the cycles from a
// load pulse until the done flag, then compares the count against a value sampled with ld.
module counter_meter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic         dn,
    input  logic [W-1:0] exp,
    output logic         busy,
    output logic         vld,
    output logic [W-1:0] cnt,
    output logic         ok,
    output logic         ovf
);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        DONE
    } state_t;

    localparam logic [W-1:0] CNT_MAX = '1;

    state_t       state, state_nx;
    logic [W-1:0] exp_lat, exp_lat_nx;
    logic [W-1:0] cnt_nx;
    logic         busy_nx, vld_nx, ok_nx, ovf_nx;

    // Every output is a flop; this block only decides what each flop loads next.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_nx   = state;
        exp_lat_nx = exp_lat;
        cnt_nx     = cnt;
        busy_nx    = busy;
        vld_nx     = vld;
        ok_nx      = ok;
        ovf_nx     = ovf;

        if (ld) begin
            // A load always wins: it aborts a running measurement or drops a held result.
            state_nx   = MEASURE;
            exp_lat_nx = exp;
            cnt_nx     = '0;
            busy_nx    = 1'b1;
            vld_nx     = 1'b0;
            ok_nx      = 1'b0;
            ovf_nx     = 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                MEASURE: begin
                    if (dn) begin
                        state_nx = DONE;
                        busy_nx  = 1'b0;
                        vld_nx   = 1'b1;
                        ok_nx    = (cnt == exp_lat) && !ovf;
                    end else if (cnt == CNT_MAX) begin
                        ovf_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                DONE: ;
                default: state_nx = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            exp_lat <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            vld     <= 1'b0;
            ok      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nx;
            exp_lat <= exp_lat_nx;
            cnt     <= cnt_nx;
            busy    <= busy_nx;
            vld     <= vld_nx;
            ok      <= ok_nx;
            ovf     <= ovf_nx;
        end
    end

endmodule

// File: tb/tb_counter_meter.sv
// Directed bench for counter_meter: an abstract model (unbounded zero-count) checked every
// cycle, plus literal expectations for each scenario.
module tb_counter_meter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ld  = 1'b0;
    logic         dn  = 1'b0;
    logic [W-1:0] exp = '0;
    logic         busy, vld, ok, ovf;
    logic [W-1:0] cnt;

    int n_cmp = 0;
    int n_bad = 0;

    counter_meter #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .ld  (ld),
        .dn  (dn),
        .exp (exp),
        .busy(busy),
        .vld (vld),
        .cnt (cnt),
        .ok  (ok),
        .ovf (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model: a measurement is the number of sampled dn=0 edges since the last ld.
    bit m_active, m_have;
    int m_zeros, m_exp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 0; m_have <= 0; m_zeros <= 0; m_exp <= 0;
        end else if (ld) begin
            m_active <= 1; m_have <= 0; m_zeros <= 0; m_exp <= int'(exp);
        end else if (m_active) begin
            if (!dn) m_zeros <= m_zeros + 1;
            else begin
                m_active <= 0;
                m_have   <= 1;
            end
        end
    end

    function automatic int m_cnt();
        return (m_zeros > 255) ? 255 : m_zeros;
    endfunction

    always @(negedge clk) begin
        check("model_busy", int'(busy), int'(m_active));
        check("model_vld",  int'(vld),  int'(m_have));
        check("model_cnt",  int'(cnt),  m_cnt());
        check("model_ovf",  int'(ovf),  int'(m_zeros > 255));
        check("model_ok",   int'(ok),   int'(m_have && m_zeros == m_exp));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse ld with expected value e, hold dn low for k edges, then raise it.
    task automatic run(input int e, input int k, output int busy_cycles);
        int i;
        ld = 1; exp = W'(e); dn = 0;
        tick(1);
        ld = 0;
        busy_cycles = 0;
        i = 0;
        while (busy && i < 400) begin
            busy_cycles++;
            if (i == k) dn = 1;
            tick(1);
            i++;
        end
        if (i >= 400) check("run_timeout", 1, 0);
    endtask

    int bc;

    initial begin
        #2;
        check("reset_busy", int'(busy), 0);
        check("reset_vld",  int'(vld),  0);
        check("reset_cnt",  int'(cnt),  0);
        tick(2);
        rst = 0;
        tick(2);
        check("idle_vld", int'(vld), 0);

        // Driven dn: k=5 -> 6 busy cycles, cnt=5, ok=1
        run(5, 5, bc);
        check("t2_busy_cycles", bc, 6);
        check("t2_vld", int'(vld), 1);
        check("t2_cnt", int'(cnt), 5);
        check("t2_ok",  int'(ok),  1);
        tick(3);
        check("t2_done_hold_cnt", int'(cnt), 5);

        // counter_91-style hookup: 92 counted edges
        dn = 0;
        tick(10);
        run(92, 92, bc);
        check("t3_cnt", int'(cnt), 92);
        check("t3_ok",  int'(ok),  1);
        run(91, 92, bc);
        check("t3b_cnt", int'(cnt), 92);
        check("t3b_ok",  int'(ok),  0);

        // Boundary: exactly 255 counted, no overflow
        run(255, 255, bc);
        check("max_cnt", int'(cnt), 255);
        check("max_ovf", int'(ovf), 0);
        check("max_ok",  int'(ok),  1);

        // Overflow
        ld = 1; exp = 8'd255; dn = 0;
        tick(1);
        ld = 0;
        tick(255);
        check("t4_cnt255", int'(cnt), 255);
        check("t4_ovf_pre", int'(ovf), 0);
        tick(1);
        check("t4_ovf", int'(ovf), 1);
        tick(44);
        check("t4_cnt_hold", int'(cnt), 255);
        check("t4_ovf_hold", int'(ovf), 1);
        dn = 1;
        tick(1);
        check("t4_vld", int'(vld), 1);
        check("t4_ok",  int'(ok),  0);

        // Restart at cnt=40
        ld = 1; exp = 8'd3; dn = 0;
        tick(1);
        ld = 0;
        tick(40);
        check("t5_cnt40", int'(cnt), 40);
        ld = 1;
        tick(1);
        check("t5_restart_cnt",  int'(cnt),  0);
        check("t5_restart_busy", int'(busy), 1);
        check("t5_restart_vld",  int'(vld),  0);
        ld = 0;
        tick(3);
        dn = 1;
        tick(1);
        check("t5_new_cnt", int'(cnt), 3);
        check("t5_new_ok",  int'(ok),  1);

        // ld and dn on the same edge mid-measurement
        ld = 1; exp = 8'd2; dn = 0;
        tick(1);
        ld = 0;
        tick(7);
        ld = 1; dn = 1;
        tick(1);
        check("t5b_cnt",  int'(cnt),  0);
        check("t5b_busy", int'(busy), 1);
        check("t5b_vld",  int'(vld),  0);
        ld = 0; dn = 0;
        tick(2);
        dn = 1;
        tick(1);
        check("t5b_new_cnt", int'(cnt), 2);
        check("t5b_new_ok",  int'(ok),  1);

        // Stale dn held from the start edge
        ld = 1; exp = 8'd0; dn = 1;
        tick(1);
        ld = 0;
        tick(1);
        check("t6_vld", int'(vld), 1);
        check("t6_cnt", int'(cnt), 0);
        check("t6_ok",  int'(ok),  1);
        ld = 1; exp = 8'd3;
        tick(1);
        ld = 0;
        tick(1);
        check("t6b_cnt", int'(cnt), 0);
        check("t6b_ok",  int'(ok),  0);

        // Asynchronous reset mid-measurement
        ld = 1; exp = 8'd9; dn = 0;
        tick(1);
        ld = 0;
        tick(6);
        check("t1_pre_cnt", int'(cnt), 6);
        #1 rst = 1;
        #1;
        check("t1_busy", int'(busy), 0);
        check("t1_vld",  int'(vld),  0);
        check("t1_cnt",  int'(cnt),  0);
        check("t1_ok",   int'(ok),   0);
        check("t1_ovf",  int'(ovf),  0);
        tick(2);
        rst = 0;
        tick(5);
        check("t1_idle_cnt", int'(cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
